// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 message sequencer and its helpers.
package sha256_pkg;

    localparam int BLOCK_W = 512;
    localparam int HASH_W  = 256;
    localparam int WORD_W  = 32;

    localparam logic [WORD_W-1:0] PAD_MARKER = 32'h8000_0000;

    localparam logic [WORD_W-1:0] SHA256_IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PAD,
        S_ZERO,
        S_LEN,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // H0 lands in the top word, matching the core_hin layout.
    function automatic logic [HASH_W-1:0] iv_flat();
        logic [HASH_W-1:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            v[HASH_W-1-WORD_W*i -: WORD_W] = SHA256_IV[i];
        end
        return v;
    endfunction

endpackage

// File: rtl/sha256_last_word_mask.sv
// Final message word: keeps the first 'bytes' bytes, clears the rest and
// merges the 0x80 padding marker right after the last valid byte.
module sha256_last_word_mask
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] data,
    input  logic [2:0]        bytes,
    output logic [WORD_W-1:0] word
);

    always_comb begin
        case (bytes)
            3'd0:    word = PAD_MARKER;
            3'd1:    word = {data[31:24], 8'h80, 16'h0000};
            3'd2:    word = {data[31:16], 8'h80, 8'h00};
            3'd3:    word = {data[31:8], 8'h80};
            default: word = data;
        endcase
    end

endmodule

// File: rtl/sha256_msg_sequencer.sv
// Packs a 32-bit big-endian word stream into padded 512-bit SHA-256 blocks,
// drives the compression core block by block and presents the final digest.
module sha256_msg_sequencer
    import sha256_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_W-1:0]  s_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_last,
    input  logic [2:0]         s_bytes,
    output logic [BLOCK_W-1:0] core_block,
    output logic [HASH_W-1:0]  core_hin,
    output logic               core_start,
    input  logic               core_done,
    input  logic [HASH_W-1:0]  core_hout,
    output logic [HASH_W-1:0]  digest,
    output logic               digest_valid,
    input  logic               digest_ack
);

    state_t state, state_nx;
    state_t ret, ret_nx;
    state_t after_wr;

    logic [WORD_W-1:0] blk [16];
    logic [3:0]        wc;
    logic [63:0]       bitlen;
    logic [HASH_W-1:0] h;
    logic              is_final;

    logic [WORD_W-1:0] last_word;
    logic              accept;
    logic              wr_en;
    logic [WORD_W-1:0] wr_data;
    logic [63:0]       len_add;
    logic              set_final;
    logic              load_h;
    logic              clear_msg;

    sha256_last_word_mask u_mask (
        .data  (s_data),
        .bytes (s_bytes),
        .word  (last_word)
    );

    assign s_ready      = !rst && (state == S_IDLE || state == S_FILL);
    assign accept       = s_valid && s_ready;
    assign core_start   = (state == S_ISSUE);
    assign digest_valid = (state == S_DONE);
    assign core_hin     = h;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            core_block[BLOCK_W-1-WORD_W*i -: WORD_W] = blk[i];
        end
    end

    always_comb begin
        state_nx  = state;
        ret_nx    = ret;
        after_wr  = state;
        wr_en     = 1'b0;
        wr_data   = '0;
        len_add   = '0;
        set_final = 1'b0;
        load_h    = 1'b0;
        clear_msg = 1'b0;

        case (state)
            S_IDLE, S_FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (!s_last) begin
                        wr_data  = s_data;
                        len_add  = 64'd32;
                        after_wr = S_FILL;
                    end else if (s_bytes >= 3'd4) begin
                        wr_data  = s_data;
                        len_add  = 64'd32;
                        after_wr = S_PAD;
                    end else begin
                        wr_data  = last_word;
                        len_add  = {58'd0, s_bytes, 3'd0};
                        after_wr = S_ZERO;
                    end
                end
            end
            S_PAD: begin
                wr_en    = 1'b1;
                wr_data  = PAD_MARKER;
                after_wr = S_ZERO;
            end
            S_ZERO: begin
                if (wc == 4'd14) begin
                    state_nx = S_LEN;
                end else begin
                    wr_en    = 1'b1;
                    after_wr = S_ZERO;
                end
            end
            S_LEN: begin
                wr_en     = 1'b1;
                wr_data   = (wc == 4'd14) ? bitlen[63:32] : bitlen[31:0];
                after_wr  = S_LEN;
                set_final = (wc == 4'd15);
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                if (core_done) begin
                    load_h   = 1'b1;
                    state_nx = is_final ? S_DONE : ret;
                end
            end
            S_DONE: begin
                if (digest_ack) begin
                    state_nx  = S_IDLE;
                    clear_msg = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // Writing word 15 completes a block: park the follow-on state in ret.
        if (wr_en) begin
            if (wc == 4'd15) begin
                state_nx = S_ISSUE;
                ret_nx   = after_wr;
            end else begin
                state_nx = after_wr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ret      <= S_FILL;
            wc       <= '0;
            bitlen   <= '0;
            h        <= iv_flat();
            is_final <= 1'b0;
            digest   <= '0;
            for (int i = 0; i < 16; i++) begin
                blk[i] <= '0;
            end
        end else begin
            state  <= state_nx;
            ret    <= ret_nx;
            bitlen <= bitlen + len_add;
            if (wr_en) begin
                blk[wc] <= wr_data;
                wc      <= wc + 4'd1;
            end
            if (set_final) begin
                is_final <= 1'b1;
            end
            if (load_h) begin
                h <= core_hout;
                if (is_final) begin
                    digest <= core_hout;
                end
            end
            if (clear_msg) begin
                h        <= iv_flat();
                bitlen   <= '0;
                is_final <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Bench for sha256_msg_sequencer: emulates the compression core and checks
// digests against a byte-level FIPS 180-4 reference model.
module tb_sha256_msg_sequencer;

    typedef logic [7:0] bytes_t [$];

    typedef struct {
        bit           tail;
        int           blocks;
        bit           known;
        logic [255:0] dig;
        int           blk_idx;
        logic [31:0]  w0;
        logic [31:0]  w15;
        bit           mid_zero;
    } vec_t;

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic         s_last;
    logic [2:0]   s_bytes;
    logic [511:0] core_block;
    logic [255:0] core_hin;
    logic         core_start;
    logic         core_done;
    logic [255:0] core_hout;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ack;

    sha256_msg_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_last       (s_last),
        .s_bytes      (s_bytes),
        .core_block   (core_block),
        .core_hin     (core_hin),
        .core_start   (core_start),
        .core_done    (core_done),
        .core_hout    (core_hout),
        .digest       (digest),
        .digest_valid (digest_valid),
        .digest_ack   (digest_ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] b);
        logic [31:0] w [64];
        logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, bb, c, d, e, f, g, hh} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = bb; bb = a; a = t1 + t2;
        end
        return {hin[255:224] + a,  hin[223:192] + bb, hin[191:160] + c, hin[159:128] + d,
                hin[127:96]  + e,  hin[95:64]   + f,  hin[63:32]    + g, hin[31:0]    + hh};
    endfunction

    // Whole-message hash from the byte string; also reports the block count.
    function automatic logic [255:0] model_hash(input bytes_t m, output int nblk);
        bytes_t       p;
        logic [63:0]  bl;
        logic [511:0] b;
        logic [255:0] hv;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(m.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        nblk = p.size() / 64;
        hv = IV;
        for (int k = 0; k < nblk; k++) begin
            for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*k+j];
            hv = compress(hv, b);
        end
        return hv;
    endfunction

    function automatic bytes_t s2b(input string s);
        bytes_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic summary();
        $display("test done: total=%0d bad=%0d", total, bad);
    endtask

    task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
        summary();
        $finish;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- compression core emulation ----------------
    int           pend = 0;
    int           core_lat = 2;
    int           nstart = 0;
    int           ndone = 0;
    int           done_cyc = 0;
    int           stable_bad = 0;
    int           ready_bad = 0;
    bit           chk_stable = 1'b1;
    logic [511:0] blk_log [$];
    logic [511:0] cap_blk;
    logic [255:0] cap_hin;
    logic [255:0] cap_out;

    initial begin
        core_done = 1'b0;
        core_hout = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (pend > 0) begin
                if (chk_stable && (core_block !== cap_blk || core_hin !== cap_hin)) stable_bad++;
                if (chk_stable && s_ready !== 1'b0) ready_bad++;
                pend--;
                if (pend == 0) begin
                    core_done = 1'b1;
                    core_hout = cap_out;
                    done_cyc  = cyc;
                    ndone++;
                end
            end else if (core_start === 1'b1) begin
                if (s_ready !== 1'b0) ready_bad++;
                nstart++;
                blk_log.push_back(core_block);
                cap_blk = core_block;
                cap_hin = core_hin;
                cap_out = compress(core_hin, core_block);
                pend    = core_lat;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_msg(input bytes_t m, input bit tail, input int gap);
        logic [31:0] wq [$];
        logic [2:0]  nq [$];
        logic [31:0] w;
        int          len, k, i, budget;
        len = m.size();
        for (k = 0; k + 4 <= len; k += 4) begin
            wq.push_back({m[k], m[k+1], m[k+2], m[k+3]});
            nq.push_back(3'd4);
        end
        if (len % 4 != 0) begin
            w = $urandom();
            for (int j = 0; j < len % 4; j++) w[31-8*j -: 8] = m[k+j];
            wq.push_back(w);
            nq.push_back(3'(len % 4));
        end else if (tail || len == 0) begin
            wq.push_back($urandom());
            nq.push_back(3'd0);
        end
        i = 0;
        budget = 0;
        while (i < wq.size()) begin
            @(negedge clk);
            if (int'($urandom_range(0, 99)) < gap) begin
                s_valid = 1'b0;
                s_data  = $urandom();
                s_last  = 1'($urandom_range(0, 1));
                s_bytes = 3'($urandom_range(0, 7));
            end else begin
                s_valid = 1'b1;
                s_data  = wq[i];
                s_last  = (i == wq.size() - 1);
                s_bytes = s_last ? nq[i] : 3'($urandom_range(0, 7));
                if (s_ready) i++;
            end
            budget++;
            if (budget > 4000) timeout_fail("send words");
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic finish_msg(input string name, input logic [255:0] exp, input int ack_delay, input bit early_ack);
        int           budget = 0;
        int           hold_bad = 0;
        logic [255:0] held;
        digest_ack = early_ack;
        do begin
            @(negedge clk); #1;
            budget++;
            if (budget > 3000) timeout_fail({name, " digest_valid"});
        end while (digest_valid !== 1'b1);
        check_vec({name, " digest"}, digest, exp);
        check_int({name, " valid after done"}, cyc - done_cyc, 1);
        if (early_ack) begin
            @(negedge clk); #1;
            digest_ack = 1'b0;
            check_vec({name, " same-cycle ack"}, 256'(digest_valid), 256'(1'b0));
        end else begin
            held = digest;
            for (int c = 0; c < ack_delay; c++) begin
                @(negedge clk); #1;
                if (digest_valid !== 1'b1 || digest !== held) hold_bad++;
            end
            check_int({name, " digest hold"}, hold_bad, 0);
            digest_ack = 1'b1;
            @(negedge clk); #1;
            digest_ack = 1'b0;
            check_vec({name, " released"}, 256'(digest_valid), 256'(1'b0));
        end
        check_vec({name, " idle ready"}, 256'(s_ready), 256'(1'b1));
    endtask

    vec_t         vecs [5];
    string        vmsg [5];
    string        vname [5];
    int           fixed_len [6] = '{55, 56, 63, 64, 119, 128};

    initial begin
        bytes_t       m;
        logic [255:0] exp;
        logic [511:0] bb;
        int           nb, base, len, budget, d0;

        vmsg[0] = "";    vname[0] = "empty";
        vecs[0] = '{tail: 0, blocks: 1, known: 1,
                    dig: 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855,
                    blk_idx: 0, w0: 32'h80000000, w15: 32'h0, mid_zero: 1};
        vmsg[1] = "abc"; vname[1] = "abc";
        vecs[1] = '{tail: 0, blocks: 1, known: 1,
                    dig: 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad,
                    blk_idx: 0, w0: 32'h61626380, w15: 32'h18, mid_zero: 1};
        vmsg[2] = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"; vname[2] = "nist56";
        vecs[2] = '{tail: 0, blocks: 2, known: 1,
                    dig: 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1,
                    blk_idx: 1, w0: 32'h0, w15: 32'h1c0, mid_zero: 1};
        vmsg[3] = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopqabcdefgh"; vname[3] = "msg64";
        vecs[3] = '{tail: 0, blocks: 2, known: 0, dig: '0,
                    blk_idx: 1, w0: 32'h80000000, w15: 32'h200, mid_zero: 1};
        vmsg[4] = "abcd"; vname[4] = "abcd_tail";
        vecs[4] = '{tail: 1, blocks: 1, known: 0, dig: '0,
                    blk_idx: 0, w0: 32'h61626364, w15: 32'h20, mid_zero: 0};

        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        s_bytes = '0;
        digest_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_vec("reset s_ready", 256'(s_ready), 256'(1'b0));
        check_vec("reset core_start", 256'(core_start), 256'(1'b0));
        check_vec("reset digest_valid", 256'(digest_valid), 256'(1'b0));
        check_vec("reset digest", digest, '0);
        check_vec("reset core_block", core_block[511:256], '0);
        check_vec("reset core_block lo", core_block[255:0], '0);
        check_vec("reset core_hin", core_hin, IV);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            m = s2b(vmsg[v]);
            exp = model_hash(m, nb);
            base = nstart;
            core_lat = 1 + v;
            send_msg(m, vecs[v].tail, 0);
            finish_msg(vname[v], vecs[v].known ? vecs[v].dig : exp, v, 1'b0);
            check_int({vname[v], " blocks"}, nstart - base, vecs[v].blocks);
            bb = blk_log[base + vecs[v].blk_idx];
            check_vec({vname[v], " word0"}, 256'(bb[511:480]), 256'(vecs[v].w0));
            check_vec({vname[v], " word15"}, 256'(bb[31:0]), 256'(vecs[v].w15));
            if (vecs[v].mid_zero) check_vec({vname[v], " words1-14"}, 256'(bb[479:32]), '0);
        end

        // Randomised messages, boundary lengths first; one with a long ack stall, one acked early.
        for (int r = 0; r < 12; r++) begin
            len = (r < 6) ? fixed_len[r] : int'($urandom_range(0, 150));
            m.delete();
            for (int j = 0; j < len; j++) m.push_back(8'($urandom_range(0, 255)));
            exp = model_hash(m, nb);
            base = nstart;
            core_lat = int'($urandom_range(1, 6));
            send_msg(m, 1'($urandom_range(0, 1)), 40);
            finish_msg($sformatf("rand%0d len%0d", r, len), exp,
                       (r == 2) ? 20 : int'($urandom_range(0, 3)), r == 3);
            check_int($sformatf("rand%0d blocks", r), nstart - base, nb);
        end

        // Reset while the core is busy; its late core_done must be ignored.
        chk_stable = 1'b0;
        core_lat = 4;
        base = nstart;
        send_msg(s2b("abc"), 1'b0, 0);
        budget = 0;
        while (nstart == base) begin
            @(negedge clk); #1;
            budget++;
            if (budget > 200) timeout_fail("rst test core_start");
        end
        @(negedge clk); #1;
        d0 = ndone;
        rst = 1'b1;
        @(negedge clk); #1;
        check_vec("midrst s_ready", 256'(s_ready), 256'(1'b0));
        check_vec("midrst core_start", 256'(core_start), 256'(1'b0));
        check_vec("midrst digest_valid", 256'(digest_valid), 256'(1'b0));
        check_vec("midrst digest", digest, '0);
        check_vec("midrst core_block", core_block[511:256] | core_block[255:0], '0);
        check_vec("midrst core_hin", core_hin, IV);
        @(negedge clk); #1;
        rst = 1'b0;
        budget = 0;
        while (ndone == d0) begin
            @(negedge clk); #1;
            budget++;
            if (budget > 50) timeout_fail("rst test stale done");
        end
        @(negedge clk); #1;
        check_vec("stale done digest_valid", 256'(digest_valid), 256'(1'b0));
        check_vec("stale done core_start", 256'(core_start), 256'(1'b0));
        check_vec("stale done s_ready", 256'(s_ready), 256'(1'b1));
        check_vec("stale done core_hin", core_hin, IV);
        chk_stable = 1'b1;
        core_lat = 2;
        base = nstart;
        send_msg(s2b("abc"), 1'b0, 0);
        finish_msg("abc after rst", 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 2, 1'b0);
        check_int("abc after rst blocks", nstart - base, 1);

        check_int("s_ready low while core busy", ready_bad, 0);
        check_int("core inputs stable while busy", stable_bad, 0);
        summary();
        $finish;
    end

endmodule

// File: doc/sha256_msg_sequencer.md
# sha256_msg_sequencer

Message-level controller for the SHA-256 compression core. It accepts an arbitrary-length byte message as a 32-bit big-endian word stream and packs it into 512-bit blocks. It applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit bit-length), issues each block to the core with the running chaining value, and presents the final 256-bit digest with a valid/ack handshake. It sits between the host/DMA stream and the compression core, which it drives one block at a time.

## Interface
- No parameters. Length counter fixed at 64 bits.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- s_data  in  32  message word, first byte in [31:24]
- s_valid  in  1  word valid
- s_ready  out  1  sequencer can accept a word
- s_last  in  1  final word of message
- s_bytes  in  3  valid bytes in final word, 0..4, left-justified; ignored unless s_last
- core_block  out  512  block to compress, word 0 in [511:480]
- core_hin  out  256  chaining value in, H0 in [255:224]
- core_start  out  1  one-cycle start pulse
- core_done  in  1  one-cycle pulse; core_hout valid
- core_hout  in  256  updated chaining value, feed-forward already added
- digest  out  256  final hash
- digest_valid  out  1  digest valid; held until acked
- digest_ack  in  1  consumer accepts digest

## Operation
- States: S_IDLE, S_FILL, S_PAD, S_ZERO, S_LEN, S_ISSUE, S_WAIT, S_DONE.
- Registers:
  - blk: 16×32 block buffer.
  - wc: 4-bit word index.
  - bitlen: 64-bit message length in bits.
  - H: 8×32 chaining value.
  - ret: state to resume after S_ISSUE.
  - final: block is the last one.
- S_IDLE: H=IV, wc=0, bitlen=0, s_ready=1.
  - First accepted word acts as in S_FILL.
- S_FILL: on s_valid&&s_ready, write blk[wc] and advance wc.
  - bitlen += 32 for a non-last word.
  - bitlen += 8·s_bytes for the last word.
- Last word, s_bytes<4:
  - Bytes beyond s_bytes are zeroed.
  - 0x80 is inserted in byte position s_bytes.
  - Next state S_ZERO.
- Last word, s_bytes==4: next state S_PAD.
- s_bytes=0 with s_last is a valid empty message (or an empty tail). The written word is 0x80000000.
- S_PAD: write 0x80000000 at blk[wc], wc++, next S_ZERO.
- S_ZERO:
  - wc==14: go to S_LEN.
  - Otherwise write zero at blk[wc], wc++.
- S_LEN: write bitlen[63:32] at word 14, then bitlen[31:0] at word 15 (2 cycles), set final.
- Wrap rule (any filling state): a write at wc==15 wraps wc to 0. Save ret = the state that would have followed, then go to S_ISSUE.
- S_ISSUE: core_start=1 for exactly one cycle, with core_block=blk and core_hin=H. Then S_WAIT.
- S_WAIT: on core_done, H←core_hout.
  - If final: go to S_DONE.
  - Otherwise: go to ret; ret is S_FILL, S_PAD or S_ZERO.
- S_DONE: digest=H, digest_valid=1.
  - On digest_ack: S_IDLE; H reloads IV.
- core_done is sampled only in S_WAIT and ignored elsewhere, including stale pulses after reset.
- bitlen wraps mod 2^64 with no error.

## Timing
- Reset values: s_ready=0, core_start=0, digest_valid=0, digest=0, core_block=0, core_hin=IV. State S_IDLE.
- s_ready=1 only in S_IDLE and S_FILL; it is low in all other states.
- Accepted throughput is 1 word per cycle until a block fills.
- Padding costs 1 cycle per written word. Issue costs 1 cycle plus the core latency.
- core_block and core_hin are stable from the core_start cycle until core_done.
- Byte counts and block count:
  - Messages of 0..55 bytes produce 1 block.
  - Messages of 56..63 bytes produce 2 blocks; the length goes in the extra block.
  - A 64-byte message produces 2 blocks.
- digest_valid rises 1 cycle after the final core_done. It stays high with digest stable while digest_ack=0.
- digest_ack in the same cycle digest_valid rises is honoured. S_IDLE then follows on the next cycle.
- rst mid-message or mid-core:
  - Abandons everything and clears all state on the next edge.
  - The core is not aborted; its later core_done is ignored.

## Structure
- sha256_pkg holds:
  - SHA256_IV[0:7].
  - The state enum.
  - Block/hash width localparams: 512, 256, 32.
  - The pad-marker constant 32'h8000_0000.
- One natural sub-module: sha256_last_word_mask. It is combinational and maps s_data and s_bytes to the masked word with 0x80 merged.

## Test plan
- "abc": one word 32'h61626300, s_bytes=3, s_last.
  - Expect 1 core_start.
  - core_block words 1..13 are 0, word 15 is 0x18.
  - digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message: s_bytes=0, s_last.
  - Expect 1 block with word 0 = 0x80000000 and bitlen 0.
  - digest=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Expect 2 core_starts.
  - Second block is all zero except word 15 = 0x1c0.
  - digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- 64-byte message, last word s_bytes=4:
  - Expect a full block, then a block starting 0x80000000 with word 15 = 0x200.
  - Digest matches the software model.
- Backpressure: s_valid toggling randomly, and digest_ack delayed 20 cycles.
  - digest remains stable and the second message hashes correctly.
  - s_ready is low throughout S_WAIT.
- rst asserted in S_WAIT, with a stale core_done arriving 3 cycles later.
  - All outputs return to reset values and the stale pulse is ignored.
  - A following "abc" message gives the correct digest.
